bn1_scale_stage: RTL and testbench

//  Batch-norm stage for layer 1, downstream of the per-channel scale ROM.
//  - Consumes the conv-1 accumulator stream, one value per beat, in channel order.
//  - Drives the ROM address (shared by the scale and bias ROMs) from an internal channel counter.
//  - Computes y = sat8(round((acc*scale) >>> SHIFT) + bias) and emits int8 activations

---
 rtl/bn_pkg.sv | 27 ++
 rtl/bn_requant.sv | 38 +++
 rtl/bn1_scale_stage.sv | 120 ++++++++++++
 tb/tb_bn1_scale_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bn_pkg.sv
// Shared constants, channel index type and int8 saturation for the layer-1 batch-norm stage.
package bn_pkg;

  localparam int ACC_W_DEF = 24;
  localparam int SHIFT_DEF = 7;
  localparam int CH_W      = 6;
  localparam int SAT_W     = 64;

  localparam logic signed [7:0] INT8_MIN = -8'sd128;
  localparam logic signed [7:0] INT8_MAX = 8'sd127;

  typedef logic [CH_W-1:0] ch_t;

  // Callers sign-extend to SAT_W so any intermediate width up to 64 bits clamps exactly.
  function automatic logic signed [7:0] sat_s8(input logic signed [SAT_W-1:0] v);
    logic signed [7:0] res;
    if (v > 64'sd127) begin
      res = INT8_MAX;
    end else if (v < -64'sd128) begin
      res = INT8_MIN;
    end else begin
      res = v[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/bn_requant.sv
// Round-half-up shift, bias add and int8 saturation of one product.
// Optional ReLU clamp when BN1_RELU_EN is defined.
module bn_requant
  import bn_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic signed [ACC_W+8:0] i_prod,
  input  logic signed [7:0]       i_bias,
  output logic signed [7:0]       o_act
);

  localparam int PROD_W = ACC_W + 9;
  localparam logic signed [PROD_W:0] HALF = {{PROD_W{1'b0}}, 1'b1} << (SHIFT - 1);

  logic signed [PROD_W:0]   w_prod_ext;
  logic signed [PROD_W:0]   w_rnd;
  logic signed [PROD_W:0]   w_shr;
  logic signed [PROD_W+1:0] w_sum;
  logic signed [SAT_W-1:0]  w_wide;
  logic signed [7:0]        w_sat;

  // One guard bit keeps the rounding add from wrapping at the most positive product.
  assign w_prod_ext = {i_prod[PROD_W-1], i_prod};
  assign w_rnd      = w_prod_ext + HALF;
  assign w_shr      = w_rnd >>> SHIFT;
  assign w_sum      = {w_shr[PROD_W], w_shr} + {{(PROD_W-6){i_bias[7]}}, i_bias};
  assign w_wide     = {{(SAT_W-PROD_W-2){w_sum[PROD_W+1]}}, w_sum};
  assign w_sat      = sat_s8(w_wide);

`ifdef BN1_RELU_EN
  assign o_act = w_sat[7] ? 8'sd0 : w_sat;
`else
  assign o_act = w_sat;
`endif

endmodule

// File: rtl/bn1_scale_stage.sv
// Layer-1 batch-norm stage: channel counter drives the scale/bias ROM address, then a
// 3-register valid/ready pipeline (capture, multiply, requantise). ReLU via BN1_RELU_EN.
module bn1_scale_stage
  import bn_pkg::*;
#(
  parameter int NUM_CH = 32,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int SHIFT  = SHIFT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [ACC_W-1:0] in_data,
  input  logic                    in_first,
  output logic [5:0]              rom_addr,
  input  logic [7:0]              scale_data,
  input  logic signed [7:0]       bias_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [7:0]       out_data,
  output logic [5:0]              out_ch
);

  localparam int PROD_W = ACC_W + 9;

  logic                     w_stall;
  logic                     w_accept;
  ch_t                      w_addr;
  logic signed [PROD_W-1:0] w_acc_ext;
  logic signed [PROD_W-1:0] w_scale_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [7:0]        w_act;

  ch_t                      r_ch_cnt;
  logic                     r_s1_valid;
  logic signed [ACC_W-1:0]  r_s1_acc;
  logic [7:0]               r_s1_scale;
  logic signed [7:0]        r_s1_bias;
  ch_t                      r_s1_ch;
  logic                     r_s2_valid;
  logic signed [PROD_W-1:0] r_s2_prod;
  logic signed [7:0]        r_s2_bias;
  ch_t                      r_s2_ch;

  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;
  assign w_accept = in_valid & in_ready;
  assign w_addr   = in_first ? '0 : r_ch_cnt;
  assign rom_addr = w_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ch_cnt <= '0;
    end else if (w_accept) begin
      r_ch_cnt <= (w_addr == ch_t'(NUM_CH - 1)) ? '0 : w_addr + 6'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_acc   <= '0;
      r_s1_scale <= '0;
      r_s1_bias  <= '0;
      r_s1_ch    <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_acc   <= in_data;
        r_s1_scale <= scale_data;
        r_s1_bias  <= bias_data;
        r_s1_ch    <= w_addr;
      end
    end
  end

  // Scale is unsigned: zero-extend so 0x80..0xff are not read as negative.
  assign w_acc_ext   = {{9{r_s1_acc[ACC_W-1]}}, r_s1_acc};
  assign w_scale_ext = {{ACC_W{1'b0}}, 1'b0, r_s1_scale};
  assign w_prod      = w_acc_ext * w_scale_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_prod  <= '0;
      r_s2_bias  <= '0;
      r_s2_ch    <= '0;
    end else if (!w_stall) begin
      r_s2_valid <= r_s1_valid;
      r_s2_prod  <= w_prod;
      r_s2_bias  <= r_s1_bias;
      r_s2_ch    <= r_s1_ch;
    end
  end

  bn_requant #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_requant (
    .i_prod (r_s2_prod),
    .i_bias (r_s2_bias),
    .o_act  (w_act)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (!w_stall) begin
      out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        out_data <= w_act;
        out_ch   <= r_s2_ch;
      end
    end
  end

endmodule

// File: tb/tb_bn1_scale_stage.sv
// Directed bench for bn1_scale_stage; ROMs modelled as arrays indexed by rom_addr.
module tb_bn1_scale_stage;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [23:0] in_data;
  logic              in_first;
  logic [5:0]        rom_addr;
  logic [7:0]        scale_data;
  logic signed [7:0] bias_data;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_data;
  logic [5:0]        out_ch;

  logic [7:0]        rom_scale [0:63];
  logic signed [7:0] rom_bias  [0:63];

  int n_tests = 0;
  int n_fail  = 0;

  assign scale_data = rom_scale[rom_addr];
  assign bias_data  = rom_bias[rom_addr];

  bn1_scale_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_first   (in_first),
    .rom_addr   (rom_addr),
    .scale_data (scale_data),
    .bias_data  (bias_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ch     (out_ch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Hand-derived channel of beat k: wraps every 32, restarts at beat 'restart' when >= 0.
  function automatic int exp_ch(input int k, input int restart);
    if (restart >= 0 && k >= restart) return (k - restart) % 32;
    return k % 32;
  endfunction

  // Single beat on channel 0; checks latency (valid only after edge N+2) and result.
  task automatic send_one(input string tag, input int acc, input int exp_data);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_first  = 1'b1;
    in_data   = 24'(acc);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    check_eq({tag, "_lat_n"}, int'(out_valid), 0);
    @(posedge clk); #1;
    check_eq({tag, "_lat_n1"}, int'(out_valid), 0);
    @(posedge clk); #1;
    check_eq({tag, "_valid"}, int'(out_valid), 1);
    check_eq({tag, "_data"}, int'(out_data), exp_data);
    check_eq({tag, "_ch"}, int'(out_ch), 0);
  endtask

  // Stream n beats with scale 1.0 and bias=channel, so beat k must yield k + ch(k).
  task automatic run_stream(input string tag, input int n, input int restart,
                            input int stall_at, input int stall_len);
    int idx_in  = 0;
    int idx_out = 0;
    int cyc     = 0;
    logic acc_fire;
    logic out_fire;
    logic prev_stall = 1'b0;
    logic signed [7:0] held = '0;
    while (idx_out < n && cyc < 400) begin
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      in_valid  = (idx_in < n);
      in_data   = 24'(idx_in);
      in_first  = (idx_in == 0) || (idx_in == restart);
      #1;
      acc_fire = in_valid & in_ready;
      out_fire = out_valid & out_ready;
      if (acc_fire) check_eq({tag, "_addr"}, int'(rom_addr), exp_ch(idx_in, restart));
      if (out_fire) begin
        check_eq({tag, "_data"}, int'(out_data), idx_out + exp_ch(idx_out, restart));
        check_eq({tag, "_ch"}, int'(out_ch), exp_ch(idx_out, restart));
        idx_out++;
      end
      if (out_valid && !out_ready) begin
        check_eq({tag, "_stall_rdy"}, int'(in_ready), 0);
        if (prev_stall) check_eq({tag, "_stall_hold"}, int'(out_data), int'(held));
        held       = out_data;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      @(posedge clk); #1;
      if (acc_fire) idx_in++;
      cyc++;
    end
    in_valid  = 1'b0;
    in_first  = 1'b0;
    out_ready = 1'b1;
    check_eq({tag, "_count"}, idx_out, n);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_first  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 64; c++) begin
      rom_scale[c] = 8'h80;
      rom_bias[c]  = 8'(c);
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_out_data", int'(out_data), 0);
    check_eq("rst_out_ch", int'(out_ch), 0);
    check_eq("rst_in_ready", int'(in_ready), 1);
    check_eq("rst_rom_addr", int'(rom_addr), 0);

    rom_scale[0] = 8'h40; rom_bias[0] = 8'sd3;
    send_one("t1_pos", 100, 53);
`ifdef BN1_RELU_EN
    send_one("t2_neg", -100, 0);
`else
    send_one("t2_neg", -100, -47);
`endif
    rom_scale[0] = 8'h7f;
    send_one("t3_satp", 10000, 127);
`ifdef BN1_RELU_EN
    send_one("t3_satn", -10000, 0);
`else
    send_one("t3_satn", -10000, -128);
`endif
    rom_scale[0] = 8'h80; rom_bias[0] = 8'sd0;
    @(posedge clk); #1;

    run_stream("t4_wrap", 70, -1, 1000, 0);
    run_stream("t4_resync", 70, 40, 1000, 0);
    run_stream("t5_stall", 20, -1, 6, 5);

    // Three beats in flight (ch 0..2), then async reset between edges.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_first  = 1'b1;
    in_data   = 24'sd5;
    @(posedge clk); #1;
    in_first = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("t6_pre_valid", int'(out_valid), 1);
    check_eq("t6_pre_addr", int'(rom_addr), 3);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_valid", int'(out_valid), 0);
    check_eq("t6_rst_data", int'(out_data), 0);
    check_eq("t6_rst_ch", int'(out_ch), 0);
    #1 rst = 1'b0;
    in_valid = 1'b1;
    in_first = 1'b0;
    in_data  = 24'sd20;
    #1;
    check_eq("t6_addr", int'(rom_addr), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("t6_drain_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    check_eq("t6_out_valid", int'(out_valid), 1);
    check_eq("t6_out_data", int'(out_data), 20);
    check_eq("t6_out_ch", int'(out_ch), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
